// File: rtl/ecc_fifo_mem_rd.sv
// ecc_fifo_mem_rd: FIFO storage array with a two-stage Hamming check/correct
// read pipeline, saturating error counters and sticky first-error address.
module ecc_fifo_mem_rd #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 5,
  parameter int PARITY_BITS = 6,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                              clk_i,
  input  logic                              rst_n_i,
  input  logic                              ecc_en_i,
  input  logic                              wr_en_i,
  input  logic [ADDR_WIDTH-1:0]             wr_addr_i,
  input  logic [DATA_WIDTH-1:0]             wr_data_i,
  input  logic [PARITY_BITS-1:0]            wr_parity_i,
  input  logic [DATA_WIDTH+PARITY_BITS-1:0] wr_inj_mask_i,
  input  logic                              rd_en_i,
  input  logic [ADDR_WIDTH-1:0]             rd_addr_i,
  output logic                              rd_valid_o,
  output logic [DATA_WIDTH-1:0]             rd_data_o,
  output logic                              sec_o,
  output logic                              ue_o,
  output logic [PARITY_BITS-1:0]            syndrome_o,
  output logic [CNT_WIDTH-1:0]              sec_cnt_o,
  output logic [CNT_WIDTH-1:0]              ue_cnt_o,
  output logic [ADDR_WIDTH-1:0]             err_addr_o,
  output logic                              err_vld_o,
  input  logic                              err_clr_i
);

  localparam int CW    = DATA_WIDTH + PARITY_BITS;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int IDX_W = $clog2(DATA_WIDTH);

  // Check bits are the XOR of the codeword positions of every set data bit;
  // data bits occupy the non-power-of-two positions in ascending order.
  function automatic logic [PARITY_BITS-1:0] calc_check(input logic [DATA_WIDTH-1:0] data);
    logic [PARITY_BITS-1:0] chk;
    logic [IDX_W-1:0]       idx;
    chk = '0;
    idx = '0;
    for (int pos = 1; pos <= CW; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        if (data[idx]) chk = chk ^ PARITY_BITS'(pos);
        idx++;
      end
    end
    return chk;
  endfunction

  // Invert the data bit whose codeword position equals the syndrome; check-bit
  // positions and out-of-range syndromes match nothing and leave data intact.
  function automatic logic [DATA_WIDTH-1:0] correct_data(input logic [DATA_WIDTH-1:0] data,
                                                         input logic [PARITY_BITS-1:0] syn);
    logic [DATA_WIDTH-1:0] res;
    logic [IDX_W-1:0]      idx;
    res = data;
    idx = '0;
    for (int pos = 1; pos <= CW; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        if (PARITY_BITS'(pos) == syn) res[idx] = ~res[idx];
        idx++;
      end
    end
    return res;
  endfunction

  logic [CW-1:0] mem [DEPTH];

  logic                   s1_vld_q, s1_vld_d;
  logic [CW-1:0]          s1_cw_q, s1_cw_d;
  logic [ADDR_WIDTH-1:0]  s1_addr_q, s1_addr_d;

  logic                   rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0]  rd_data_q, rd_data_d;
  logic                   sec_q, sec_d;
  logic                   ue_q, ue_d;
  logic [PARITY_BITS-1:0] syndrome_q, syndrome_d;
  logic [CNT_WIDTH-1:0]   sec_cnt_q, sec_cnt_d;
  logic [CNT_WIDTH-1:0]   ue_cnt_q, ue_cnt_d;
  logic [ADDR_WIDTH-1:0]  err_addr_q, err_addr_d;
  logic                   err_vld_q, err_vld_d;

  logic [PARITY_BITS-1:0] syn_raw;
  logic                   syn_sec;
  logic                   syn_ue;

  // Storage array: not reset; nonblocking update gives read-before-write.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem[wr_addr_i] <= {wr_parity_i, wr_data_i} ^ wr_inj_mask_i;
  end

  // Stage 1: capture the raw codeword and its address on a read request.
  always_comb begin
    s1_vld_d  = rd_en_i;
    s1_cw_d   = s1_cw_q;
    s1_addr_d = s1_addr_q;
    if (rd_en_i) begin
      s1_cw_d   = mem[rd_addr_i];
      s1_addr_d = rd_addr_i;
    end
  end

  // Stage 2: syndrome, correction, counters and first-error capture.
  always_comb begin
    syn_raw    = calc_check(s1_cw_q[DATA_WIDTH-1:0]) ^ s1_cw_q[CW-1:DATA_WIDTH];
    syn_sec    = (syn_raw != '0) && (syn_raw <= PARITY_BITS'(CW));
    syn_ue     = (syn_raw > PARITY_BITS'(CW));
    rd_valid_d = s1_vld_q;
    rd_data_d  = rd_data_q;
    sec_d      = sec_q;
    ue_d       = ue_q;
    syndrome_d = syndrome_q;
    sec_cnt_d  = sec_cnt_q;
    ue_cnt_d   = ue_cnt_q;
    err_addr_d = err_addr_q;
    err_vld_d  = err_vld_q;
    if (s1_vld_q) begin
      if (ecc_en_i) begin
        rd_data_d  = correct_data(s1_cw_q[DATA_WIDTH-1:0], syn_raw);
        syndrome_d = syn_raw;
        sec_d      = syn_sec;
        ue_d       = syn_ue;
        if (syn_sec && (sec_cnt_q != {CNT_WIDTH{1'b1}})) sec_cnt_d = sec_cnt_q + CNT_WIDTH'(1);
        if (syn_ue && (ue_cnt_q != {CNT_WIDTH{1'b1}}))   ue_cnt_d  = ue_cnt_q + CNT_WIDTH'(1);
        if ((syn_sec || syn_ue) && !err_vld_q) begin
          err_addr_d = s1_addr_q;
          err_vld_d  = 1'b1;
        end
      end else begin
        rd_data_d  = s1_cw_q[DATA_WIDTH-1:0];
        syndrome_d = '0;
        sec_d      = 1'b0;
        ue_d       = 1'b0;
      end
    end
    if (err_clr_i) begin
      sec_cnt_d  = '0;
      ue_cnt_d   = '0;
      err_addr_d = '0;
      err_vld_d  = 1'b0;
    end
  end

  // Pipeline and status registers; async reset drops any in-flight read.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_vld_q   <= 1'b0;
      s1_cw_q    <= '0;
      s1_addr_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      sec_q      <= 1'b0;
      ue_q       <= 1'b0;
      syndrome_q <= '0;
      sec_cnt_q  <= '0;
      ue_cnt_q   <= '0;
      err_addr_q <= '0;
      err_vld_q  <= 1'b0;
    end else begin
      s1_vld_q   <= s1_vld_d;
      s1_cw_q    <= s1_cw_d;
      s1_addr_q  <= s1_addr_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      sec_q      <= sec_d;
      ue_q       <= ue_d;
      syndrome_q <= syndrome_d;
      sec_cnt_q  <= sec_cnt_d;
      ue_cnt_q   <= ue_cnt_d;
      err_addr_q <= err_addr_d;
      err_vld_q  <= err_vld_d;
    end
  end

  assign rd_valid_o = rd_valid_q;
  assign rd_data_o  = rd_data_q;
  assign sec_o      = sec_q;
  assign ue_o       = ue_q;
  assign syndrome_o = syndrome_q;
  assign sec_cnt_o  = sec_cnt_q;
  assign ue_cnt_o   = ue_cnt_q;
  assign err_addr_o = err_addr_q;
  assign err_vld_o  = err_vld_q;

endmodule

// File: doc/ecc_fifo_mem_rd.md
Name: ecc_fifo_mem_rd

Overview:
- Storage and read-side ECC stage of the sync FIFO. Sits directly downstream of the write-side parity calculator.
- Captures each write as one codeword {check bits, data}: data from the calculator's data_out, check bits from its parity_out.
- On read, recomputes the Hamming check bits, corrects single-position errors and flags uncorrectable syndromes.
- Exposes a valid-qualified read pipeline, saturating error counters and a sticky first-error address for the FIFO controller and CSR block.

Parameters:
- DATA_WIDTH, 32, data bits per entry. The code is defined for 32 only.
- ADDR_WIDTH, 5, address bits; depth is 2**ADDR_WIDTH.
- PARITY_BITS, 6, Hamming check bits. The code is defined for 6 only.
- CNT_WIDTH, 8, width of each error counter.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  reset; asynchronous assert, active-low.
- ecc_en_i  in  1  1 = ECC checking and correction on the read path.
- wr_en_i  in  1  write strobe (from calculator wr_en_o).
- wr_addr_i  in  ADDR_WIDTH  write address.
- wr_data_i  in  DATA_WIDTH  write data.
- wr_parity_i  in  PARITY_BITS  check bits [6:1].
- wr_inj_mask_i  in  DATA_WIDTH+PARITY_BITS  error-injection mask, XORed into the stored codeword.
- rd_en_i  in  1  read request.
- rd_addr_i  in  ADDR_WIDTH  read address.
- rd_valid_o  out  1  read result valid.
- rd_data_o  out  DATA_WIDTH  corrected read data.
- sec_o  out  1  single error corrected; qualified by rd_valid_o.
- ue_o  out  1  uncorrectable syndrome; qualified by rd_valid_o.
- syndrome_o  out  PARITY_BITS  syndrome of the current result.
- sec_cnt_o  out  CNT_WIDTH  saturating count of corrected errors.
- ue_cnt_o  out  CNT_WIDTH  saturating count of uncorrectable errors.
- err_addr_o  out  ADDR_WIDTH  address of the first error since clear.
- err_vld_o  out  1  err_addr_o holds a captured address.
- err_clr_i  in  1  synchronous clear of counters, err_vld_o and err_addr_o.

Behaviour:
- Reset (async, rst_n_i=0): all outputs and pipeline registers go to 0. Memory contents are not reset.
- Reset mid-read: any in-flight result is dropped; no rd_valid_o pulse follows reset release.
- Codeword layout: bits [DATA_WIDTH-1:0] = data; bit DATA_WIDTH+k-1 = parity[k].
- Write: on wr_en_i at a rising edge, mem[wr_addr_i] <= {wr_parity_i, wr_data_i} ^ wr_inj_mask_i.
- Stage 1 (read): rd_en_i at edge N latches mem[rd_addr_i] and rd_addr_i into stage-1 registers.
- Read/write same address in the same cycle: the read returns the OLD contents (read-before-write).
- Stage 2 (check): at edge N+1 the result registers update and rd_valid_o=1 for one cycle. Total read latency is 2 cycles.
- Throughput: back-to-back rd_en_i gives one result per cycle.
- Check-bit recomputation uses the same Hamming code as the write side:
  - check bit k sits at position 2**(k-1), k=1..6;
  - data bits 0..31 fill the non-power-of-two positions 3,5,6,7,9,...,38 in ascending order;
  - check bit k is the XOR of every data bit whose position has bit k-1 set (e.g. p1 covers data 0,1,3,4,6,8,10,11,...,30).
- Syndrome: recomputed check bits XOR stored check bits.
  - syndrome 0: clean; data passes through; sec_o=ue_o=0.
  - syndrome a power of two: the check bit itself is in error; data passes through; sec_o=1.
  - syndrome a data position (3..38, not a power of two): invert the data bit at that position; sec_o=1.
  - syndrome 39..63: data passes through uncorrected; ue_o=1.
- ecc_en_i=0: no correction; syndrome_o=0, sec_o=ue_o=0; counters and err_addr_o hold.
- ecc_en_i is sampled at stage 2.
- When rd_valid_o=0: rd_data_o, sec_o, ue_o and syndrome_o hold their last values.
- Counters: increment on a valid result with sec_o (respectively ue_o). They saturate at all-ones with no wrap.
- First-error capture: on the first valid result with sec_o or ue_o while err_vld_o=0, err_addr_o <= stage-1 address and err_vld_o <= 1. Later errors do not overwrite the captured address.
- err_clr_i: clears counters, err_vld_o and err_addr_o. err_clr_i has priority over a same-cycle increment or capture; that same-cycle event is lost.

Test Plan:
- Clean path: write addr 3, data 0x00000001, parity 6'b000011, mask 0; read addr 3 -> rd_valid_o 2 cycles after rd_en_i, rd_data_o=0x00000001, syndrome_o=0, sec_o=ue_o=0.
- Single data-bit error: write addr 0, data 0, parity 0, mask bit 5; read -> syndrome_o=10, rd_data_o=0, sec_o=1, sec_cnt_o=1, err_addr_o=0, err_vld_o=1.
- Check-bit error and uncorrectable syndrome: mask parity[6] only -> syndrome_o=32, data unchanged, sec_o=1. Mask parity[6] plus data bit 3 -> syndrome_o=39, ue_o=1, rd_data_o=0x00000008, ue_cnt_o=1.
- Collision and streaming: write 0xDEADBEEF to addr 7, then in one cycle write addr 7 and read addr 7 -> read returns 0xDEADBEEF. Reads on 4 consecutive cycles -> 4 consecutive rd_valid_o pulses.
- Saturation and clear: 260 reads of a single-error entry -> sec_cnt_o=255. err_clr_i asserted with a same-cycle error result -> counters 0, err_vld_o=0.
- Reset and ECC off: assert rst_n_i while a read is in flight -> all outputs 0 and no valid pulse after release. ecc_en_i=0 with a mask-corrupted entry -> raw data returned, sec_o=ue_o=0, counters unchanged.
